// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Client (inst/data) and memory-side signals of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        INST_FLUSH;
  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN;
  logic [3:0]  DATA_WSTRB;
  logic [31:0] DATA_WADDR;
  logic [31:0] DATA_WDATA;
  logic        INST_WAIT;
  logic        DATA_WAIT;
  logic        MEM_RDEN;
  logic [31:0] MEM_RIADDR;
  logic [31:0] MEM_ROADDR;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        MEM_WREN;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_WAIT;

  // Arbiter view
  modport slave (
    input  INST_RDEN, INST_RIADDR, INST_FLUSH,
    input  DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
    input  MEM_ROADDR, MEM_RVALID, MEM_RDATA, MEM_WAIT,
    output INST_ROADDR, INST_RVALID, INST_RDATA,
    output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    output INST_WAIT, DATA_WAIT,
    output MEM_RDEN, MEM_RIADDR, MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA
  );

  // Environment view (MMU channels plus memory)
  modport master (
    output INST_RDEN, INST_RIADDR, INST_FLUSH,
    output DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
    output MEM_ROADDR, MEM_RVALID, MEM_RDATA, MEM_WAIT,
    input  INST_ROADDR, INST_RVALID, INST_RDATA,
    input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    input  INST_WAIT, DATA_WAIT,
    input  MEM_RDEN, MEM_RIADDR, MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction and data channels,
//            one read outstanding, responses routed back to the issuer.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus
);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_INST = 2'd1,
    S_RD_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_DRD  = 2'd2,
    SEL_IRD  = 2'd3
  } sel_t;

  state_t     r_state;
  sel_t       r_hold_sel;
  logic       r_hold_vld;
  logic [3:0] r_starve_cnt;
  logic       r_drop;

  logic w_resp;
  logic w_can_issue;
  logic w_hold_ok;
  sel_t w_sel;
  logic w_acc;
  logic w_inst_acc;
  logic w_data_acc;
  logic w_inst_rvalid;
  logic w_data_rvalid;

  always_comb begin
    w_resp      = (r_state != S_IDLE) && bus.MEM_RVALID;
    w_can_issue = !RST && ((r_state == S_IDLE) || w_resp);
    w_hold_ok   = r_hold_vld &&
                  (((r_hold_sel == SEL_WR)  && bus.DATA_WREN) ||
                   ((r_hold_sel == SEL_DRD) && bus.DATA_RDEN) ||
                   ((r_hold_sel == SEL_IRD) && bus.INST_RDEN));
    w_sel = SEL_NONE;
    if (w_can_issue) begin
      // A stalled winner keeps the port until memory takes it.
      if (w_hold_ok)
        w_sel = r_hold_sel;
      else if ((r_starve_cnt == c_STARVE_MAX) && bus.INST_RDEN)
        w_sel = SEL_IRD;
      else if (bus.DATA_WREN)
        w_sel = SEL_WR;
      else if (bus.DATA_RDEN)
        w_sel = SEL_DRD;
      else if (bus.INST_RDEN)
        w_sel = SEL_IRD;
    end
    w_acc         = (w_sel != SEL_NONE) && !bus.MEM_WAIT;
    w_inst_acc    = w_acc && (w_sel == SEL_IRD);
    w_data_acc    = w_acc && ((w_sel == SEL_WR) || (w_sel == SEL_DRD));
    w_inst_rvalid = (r_state == S_RD_INST) && bus.MEM_RVALID && !(r_drop || bus.INST_FLUSH);
    w_data_rvalid = (r_state == S_RD_DATA) && bus.MEM_RVALID;
  end

  assign bus.MEM_RDEN   = (w_sel == SEL_IRD) || (w_sel == SEL_DRD);
  assign bus.MEM_RIADDR = (w_sel == SEL_IRD) ? bus.INST_RIADDR :
                          (w_sel == SEL_DRD) ? bus.DATA_RIADDR : 32'd0;
  assign bus.MEM_WREN   = (w_sel == SEL_WR);
  assign bus.MEM_WSTRB  = (w_sel == SEL_WR) ? bus.DATA_WSTRB : 4'd0;
  assign bus.MEM_WADDR  = (w_sel == SEL_WR) ? bus.DATA_WADDR : 32'd0;
  assign bus.MEM_WDATA  = (w_sel == SEL_WR) ? bus.DATA_WDATA : 32'd0;

  assign bus.INST_WAIT  = !RST && bus.INST_RDEN && !w_inst_acc;
  assign bus.DATA_WAIT  = !RST && (bus.DATA_RDEN || bus.DATA_WREN) && !w_data_acc;

  assign bus.INST_RVALID = w_inst_rvalid;
  assign bus.INST_ROADDR = w_inst_rvalid ? bus.MEM_ROADDR : 32'd0;
  assign bus.INST_RDATA  = w_inst_rvalid ? bus.MEM_RDATA  : 32'd0;
  assign bus.DATA_RVALID = w_data_rvalid;
  assign bus.DATA_ROADDR = w_data_rvalid ? bus.MEM_ROADDR : 32'd0;
  assign bus.DATA_RDATA  = w_data_rvalid ? bus.MEM_RDATA  : 32'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_hold_vld   <= 1'b0;
      r_hold_sel   <= SEL_NONE;
      r_starve_cnt <= 4'd0;
      r_drop       <= 1'b0;
    end else begin
      if (w_can_issue) begin
        if (w_inst_acc)
          r_state <= S_RD_INST;
        else if (w_acc && (w_sel == SEL_DRD))
          r_state <= S_RD_DATA;
        else
          r_state <= S_IDLE;
      end

      r_hold_vld <= (w_sel != SEL_NONE) && bus.MEM_WAIT;
      r_hold_sel <= w_sel;

      if (!bus.INST_RDEN || w_inst_acc)
        r_starve_cnt <= 4'd0;
      else if (w_data_acc && (r_starve_cnt != c_STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + 4'd1;

      // A flush in the accept cycle marks the new read, so it wins over the clear.
      if (w_inst_acc && bus.INST_FLUSH)
        r_drop <= 1'b1;
      else if ((r_state == S_RD_INST) && bus.MEM_RVALID)
        r_drop <= 1'b0;
      else if ((r_state == S_RD_INST) && bus.INST_FLUSH)
        r_drop <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one physical memory port between the instruction-read channel and the data read/write channel that leave the MMU. The arbiter is placed between the MMU's physical-address outputs and a single-ported memory/bus master. It serialises transactions and keeps at most one read outstanding. It routes each read response back to the channel that issued it and applies backpressure per channel.

Parameters:
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending instruction read gets top priority (1..15)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous reset, active-high
INST_RDEN  in  1  instruction read request (level, held until accepted)
INST_RIADDR  in  32  instruction read address
INST_ROADDR  out  32  address of returned instruction word
INST_RVALID  out  1  instruction response valid (1 cycle)
INST_RDATA  out  32  instruction data
INST_FLUSH  in  1  discard any outstanding instruction response
DATA_RDEN  in  1  data read request (level)
DATA_RIADDR  in  32  data read address
DATA_ROADDR  out  32  address of returned data word
DATA_RVALID  out  1  data response valid (1 cycle)
DATA_RDATA  out  32  data read data
DATA_WREN  in  1  data write request (level)
DATA_WSTRB  in  4  byte strobes
DATA_WADDR  in  32  write address
DATA_WDATA  in  32  write data
INST_WAIT  out  1  instruction request not accepted this cycle
DATA_WAIT  out  1  data request (read or write) not accepted this cycle
MEM_RDEN  out  1  read issue
MEM_RIADDR  out  32  read address
MEM_ROADDR  in  32  echoed read address
MEM_RVALID  in  1  read response valid
MEM_RDATA  in  32  read data
MEM_WREN  out  1  write issue
MEM_WSTRB  out  4  write strobes
MEM_WADDR  out  32  write address
MEM_WDATA  out  32  write data
MEM_WAIT  in  1  memory cannot accept an issue this cycle

Behaviour:
- Reset: state=IDLE, starve_cnt=0, owner=NONE, drop flag=0. All MEM_* enables are 0 and all *_RVALID are 0. INST_WAIT and DATA_WAIT are 0. Address and data outputs are 0.
- States:
  - IDLE: no transaction outstanding.
  - RD_INST: instruction read outstanding.
  - RD_DATA: data read outstanding.
- Issue happens only in IDLE, or in the same cycle a response completes. At most one issue per cycle.
- Priority among pending requests:
  - If starve_cnt==STARVE_LIMIT and INST_RDEN: instruction read first.
  - Otherwise: data write, then data read, then instruction read.
  - Data write and data read both asserted: the write goes first.
- Issue is combinational from the winner. MEM_RDEN or MEM_WREN=1 with the winner's address, strobes and data.
- A request is accepted when it is issued and MEM_WAIT=0.
  - If MEM_WAIT=1, nothing is accepted.
  - The same winner is re-presented next cycle; no re-arbitration while MEM_WAIT is held.
- INST_WAIT = INST_RDEN and instruction read not accepted this cycle. DATA_WAIT is defined the same way for DATA_RDEN or DATA_WREN.
- Write: completes on acceptance with no response phase. State stays IDLE.
- Read accepted: state moves to RD_INST or RD_DATA next cycle.
- Response routing: in RD_x, MEM_RVALID=1 drives the x_RVALID/x_ROADDR/x_RDATA pass-through in the same cycle (combinational, 0 added latency). State returns to IDLE. A new issue is allowed in that same cycle.
- MEM_RVALID in IDLE is ignored.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each cycle where INST_RDEN=1 and a data request is accepted.
  - It clears when an instruction read is accepted, or when INST_RDEN=0.
- INST_FLUSH:
  - In RD_INST, or in the cycle an instruction read is accepted, the drop flag is set.
  - The matching response is consumed with INST_RVALID forced to 0, and the drop flag clears.
  - INST_FLUSH together with MEM_RVALID in RD_INST drops that response.
  - INST_FLUSH has no effect on data channels or in RD_DATA/IDLE with nothing outstanding.
- Reset asserted mid-transaction returns the block to IDLE immediately. Any later MEM_RVALID is then ignored.

Test Plan:
1. Reset mid RD_DATA, then MEM_RVALID=1 -> all outputs 0, state IDLE, DATA_RVALID stays 0.
2. INST_RDEN=1 @0x100, memory returns RDATA=0xDEADBEEF two cycles later -> one MEM_RDEN pulse, INST_RVALID=1 for 1 cycle with ROADDR=0x100, INST_WAIT=0 at issue.
3. DATA_WREN (WADDR=0x2000, WSTRB=0xF) and INST_RDEN in the same cycle -> write issued first, INST_WAIT=1. The instruction read is issued the next cycle.
4. MEM_WAIT=1 for 3 cycles during a data read -> MEM_RDEN and address held constant, DATA_WAIT=1 for 3 cycles. Accepted on the 4th cycle.
5. STARVE_LIMIT=4, continuous data writes plus INST_RDEN -> after 4 accepted writes the instruction read is issued, DATA_WAIT=1 for that cycle, and starve_cnt returns to 0.
6. Instruction read outstanding, INST_FLUSH pulsed, then MEM_RVALID -> INST_RVALID stays 0 and state returns to IDLE. A following data read completes normally.
